// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// One transaction in flight at a time; ties alternate; RESP aborts after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic       OwnFetch    = 1'b0;
  localparam logic       OwnData     = 1'b1;
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic        owner_q;
  logic        last_owner_q;
  logic [7:0]  tmo_cnt_q;
  logic        cmd_we_q;
  logic [3:0]  cmd_be_q;
  logic [31:0] cmd_addr_q;
  logic [31:0] cmd_wdata_q;
  logic        i_rvalid_q;
  logic        d_rvalid_q;
  logic        d_err_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  logic pick_data;
  logic grant_en;

  // Data wins when it is alone, or on a tie when fetch had the previous grant.
  always_comb begin
    pick_data = d_req && (!i_req || (last_owner_q == OwnFetch));
    grant_en  = !reset && (state_q == StIdle) && (i_req || d_req);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnFetch;
      last_owner_q <= OwnFetch;
      tmo_cnt_q    <= 8'd0;
      cmd_we_q     <= 1'b0;
      cmd_be_q     <= 4'd0;
      cmd_addr_q   <= 32'd0;
      cmd_wdata_q  <= 32'd0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      d_err_q      <= 1'b0;
      i_rdata_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_en) begin
            owner_q      <= pick_data;
            last_owner_q <= pick_data;
            state_q      <= StIssue;
            if (pick_data) begin
              cmd_we_q    <= d_we;
              cmd_be_q    <= d_be;
              cmd_addr_q  <= d_addr;
              cmd_wdata_q <= d_wdata;
            end else begin
              cmd_we_q    <= 1'b0;
              cmd_be_q    <= 4'b1111;
              cmd_addr_q  <= i_addr;
              cmd_wdata_q <= 32'd0;
            end
          end
        end
        StIssue: begin
          if (m_ack) begin
            tmo_cnt_q <= 8'd0;
            state_q   <= StResp;
          end
        end
        StResp: begin
          // A response in the timeout cycle still counts as a normal completion.
          if (m_rvalid) begin
            state_q <= StIdle;
            if (owner_q == OwnData) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= m_rdata;
            end else begin
              i_rvalid_q <= 1'b1;
              i_rdata_q  <= m_rdata;
            end
          end else if (tmo_cnt_q == TimeoutLast) begin
            state_q <= StIdle;
            if (owner_q == OwnData) begin
              d_rvalid_q <= 1'b1;
              d_err_q    <= 1'b1;
              d_rdata_q  <= 32'd0;
            end else begin
              i_rvalid_q <= 1'b1;
              i_rdata_q  <= 32'd0;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are forced low combinationally so they read zero in the first reset cycle too.
  always_comb begin
    i_gnt    = grant_en && !pick_data;
    d_gnt    = grant_en && pick_data;
    m_req    = !reset && (state_q == StIssue);
    m_we     = reset ? 1'b0  : cmd_we_q;
    m_be     = reset ? 4'd0  : cmd_be_q;
    m_addr   = reset ? 32'd0 : cmd_addr_q;
    m_wdata  = reset ? 32'd0 : cmd_wdata_q;
    i_rvalid = !reset && i_rvalid_q;
    d_rvalid = !reset && d_rvalid_q;
    d_err    = !reset && d_err_q;
    i_rdata  = reset ? 32'd0 : i_rdata_q;
    d_rdata  = reset ? 32'd0 : d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, alternating ties, timeout, reset, backpressure.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ack, m_rvalid;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_d;
    reset = 1'b1; i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_be = 4'h0;
    d_addr = 32'h0; d_wdata = 32'h0; m_ack = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    #1;
    check("rst_i_gnt", i_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    tick();
    check("rst_m_req", m_req, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_i_rdata", i_rdata, 0);

    // Single fetch
    tick(); reset = 1'b0; d_req = 1'b0; i_req = 1'b1; i_addr = 32'h100; #1;
    check("f_i_gnt", i_gnt, 1);
    check("f_d_gnt", d_gnt, 0);
    check("f_idle_mreq", m_req, 0);
    tick(); i_req = 1'b0; i_addr = 32'h0; m_ack = 1'b1; #1;
    check("f_m_req", m_req, 1);
    check("f_m_addr", m_addr, 32'h100);
    check("f_m_we", m_we, 0);
    check("f_m_be", m_be, 4'hF);
    check("f_no_gnt", i_gnt, 0);
    tick(); m_ack = 1'b0; #1;
    check("f_resp_mreq", m_req, 0);
    tick(); m_rvalid = 1'b1; m_rdata = 32'h00500093; #1;
    check("f_no_early_rv", i_rvalid, 0);
    tick(); m_rvalid = 1'b0; m_rdata = 32'h0; #1;
    check("f_i_rvalid", i_rvalid, 1);
    check("f_i_rdata", i_rdata, 32'h00500093);
    check("f_d_rvalid", d_rvalid, 0);
    tick();
    check("f_rv_pulse", i_rvalid, 0);
    check("f_rdata_hold", i_rdata, 32'h00500093);

    // Tie after reset: D,I,D,I
    reset = 1'b1;
    tick(); reset = 1'b0; i_req = 1'b1; i_addr = 32'h80; d_req = 1'b1; d_we = 1'b1;
    d_be = 4'b0100; d_addr = 32'h204; d_wdata = 32'h00AB0000; #1;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      check("tie_d_gnt", d_gnt, exp_d);
      check("tie_i_gnt", i_gnt, !exp_d);
      if (k > 0) check("tie_prev_rv", exp_d ? i_rvalid : d_rvalid, 1);
      tick(); m_ack = 1'b1; #1;
      check("tie_m_req", m_req, 1);
      check("tie_m_we", m_we, exp_d);
      check("tie_m_be", m_be, exp_d ? 32'h4 : 32'hF);
      check("tie_m_addr", m_addr, exp_d ? 32'h204 : 32'h80);
      if (exp_d) check("tie_m_wdata", m_wdata, 32'h00AB0000);
      tick(); m_ack = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1000 + k;
      tick(); m_rvalid = 1'b0;
      if (k == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      #1;
    end
    check("tie_last_rv", i_rvalid, 1);
    check("tie_i_rdata", i_rdata, 32'h1003);
    check("tie_d_rdata", d_rdata, 32'h1002);
    check("tie_no_err", d_err, 0);

    // Timeout on a data read
    tick(); d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300; #1;
    check("to_d_gnt", d_gnt, 1);
    tick(); d_req = 1'b0; m_ack = 1'b1; #1;
    check("to_m_we", m_we, 0);
    tick(); m_ack = 1'b0;
    for (int r = 0; r < 4; r++) begin
      #1;
      check("to_wait_rv", d_rvalid, 0);
      check("to_wait_mreq", m_req, 0);
      tick();
    end
    #1;
    check("to_d_rvalid", d_rvalid, 1);
    check("to_d_err", d_err, 1);
    check("to_d_rdata", d_rdata, 0);
    check("to_i_rvalid", i_rvalid, 0);
    m_rvalid = 1'b1; m_rdata = 32'hBAD;
    tick(); m_rvalid = 1'b0; #1;
    check("to_stray_rv", d_rvalid, 0);
    check("to_stray_err", d_err, 0);
    check("to_stray_irv", i_rvalid, 0);
    check("to_d_rdata_hold", d_rdata, 0);

    // Backpressure: m_ack low for 10 ISSUE cycles
    tick(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h400;
    d_wdata = 32'hCAFEF00D; #1;
    check("bp_d_gnt", d_gnt, 1);
    tick(); d_req = 1'b0; d_addr = 32'hDEAD; d_wdata = 32'h0; i_req = 1'b1;
    i_addr = 32'h500; m_rvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp_m_req", m_req, 1);
      check("bp_m_addr", m_addr, 32'h400);
      check("bp_m_wdata", m_wdata, 32'hCAFEF00D);
      check("bp_no_gnt", i_gnt, 0);
      check("bp_no_rv", d_rvalid, 0);
      tick();
    end
    m_rvalid = 1'b0; m_ack = 1'b1; #1;
    check("bp_m_be", m_be, 4'b0011);
    tick(); m_ack = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77; #1;
    check("bp_resp_mreq", m_req, 0);
    tick(); m_rvalid = 1'b0; #1;
    check("bp_d_rvalid", d_rvalid, 1);
    check("bp_d_err", d_err, 0);
    check("bp_i_gnt", i_gnt, 1);

    // Reset in RESP of the fetch just granted
    tick(); i_req = 1'b0; m_ack = 1'b1; #1;
    check("rm_m_addr", m_addr, 32'h500);
    tick(); m_ack = 1'b0; reset = 1'b1; i_req = 1'b1; i_addr = 32'h600; #1;
    check("rm_m_req", m_req, 0);
    check("rm_i_gnt", i_gnt, 0);
    check("rm_m_addr0", m_addr, 0);
    check("rm_m_wdata0", m_wdata, 0);
    check("rm_m_be0", m_be, 0);
    check("rm_i_rdata0", i_rdata, 0);
    check("rm_d_rdata0", d_rdata, 0);
    tick();
    check("rm_i_rv", i_rvalid, 0);
    check("rm_gnt2", i_gnt, 0);
    tick(); reset = 1'b0; i_req = 1'b0; #1;
    check("rm_post_irv", i_rvalid, 0);
    check("rm_post_drv", d_rvalid, 0);
    m_rvalid = 1'b1; m_rdata = 32'h5555;
    tick(); m_rvalid = 1'b0; #1;
    check("rm_late_irv", i_rvalid, 0);
    check("rm_late_drv", d_rvalid, 0);
    i_req = 1'b1; i_addr = 32'h600; #1;
    check("rm_new_gnt", i_gnt, 1);
    tick(); i_req = 1'b0; m_ack = 1'b1; #1;
    check("rm_new_addr", m_addr, 32'h600);
    tick(); m_ack = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234;
    tick(); m_rvalid = 1'b0; #1;
    check("rm_new_rv", i_rvalid, 1);
    check("rm_new_rdata", i_rdata, 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
